stepper_move_sequencer: RTL

STEPPER_MOVE_SEQUENCER -- requirements
Module: stepper_move_sequencer

---
 rtl/stepper_move_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/stepper_move_sequencer.sv
// Sequences signed-count step moves for an A4988 driver (DIR setup, STEP pulse train, soft limits).
// Latency: first STEP rise DIR_SETUP+1 cycles after command accept; done one cycle after the move ends.
// Backpressure: cmd_ready is high only in IDLE; commands presented while busy wait for the next IDLE.
module stepper_move_sequencer #(
  parameter int                 HALF_PERIOD = 50000,
  parameter int                 DIR_SETUP   = 100,
  parameter logic signed [15:0] POS_MIN     = -16'sd3200,
  parameter logic signed [15:0] POS_MAX     = 16'sd3200
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic signed [15:0] cmd_steps,
  input  logic               abort,
  output logic               dir,
  output logic               step,
  output logic               busy,
  output logic               done,
  output logic signed [15:0] position,
  output logic [1:0]         status
);

  // One shared counter times both the DIR setup window and each STEP half period.
  localparam int CNT_MAX = (HALF_PERIOD > DIR_SETUP) ? HALF_PERIOD : DIR_SETUP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] DS_LAST  = CW'((DIR_SETUP > 0) ? DIR_SETUP - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] ST_COMPLETE = 2'b00;
  localparam logic [1:0] ST_ABORTED  = 2'b01;
  localparam logic [1:0] ST_LIMIT    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [15:0]          remaining, remaining_nxt;
  logic signed [15:0]   position_nxt;
  logic                 dir_nxt;
  logic [1:0]           status_nxt;
  logic                 abort_pend, abort_pend_nxt;
  logic                 want_high;
  logic [15:0]          steps_raw;
  logic                 at_limit;

  assign steps_raw = $unsigned(cmd_steps);

  // Outputs decoded directly from the registered state.
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign step      = (state == S_HIGH);

  // Next-state and datapath: abort is resolved before any limit check so it always wins.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    remaining_nxt  = remaining;
    position_nxt   = position;
    dir_nxt        = dir;
    status_nxt     = status;
    abort_pend_nxt = abort_pend;
    want_high      = 1'b0;
    at_limit       = 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_steps == 16'sd0) begin
            state_nxt  = S_DONE;
            status_nxt = ST_COMPLETE;
          end else begin
            // Magnitude as unsigned so -32768 maps to 32768 steps.
            remaining_nxt  = cmd_steps[15] ? (~steps_raw + 16'd1) : steps_raw;
            dir_nxt        = ~cmd_steps[15];
            cnt_nxt        = '0;
            abort_pend_nxt = 1'b0;
            if (DIR_SETUP == 0) begin
              want_high = 1'b1;
            end else begin
              state_nxt = S_SETUP;
            end
          end
        end
      end

      S_SETUP: begin
        if (abort) begin
          state_nxt  = S_DONE;
          status_nxt = ST_ABORTED;
        end else if (cnt == DS_LAST) begin
          want_high = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      S_HIGH: begin
        // A pulse is never truncated; remember the abort and act on it at pulse end.
        if (abort) begin
          abort_pend_nxt = 1'b1;
        end
        if (cnt == HP_LAST) begin
          cnt_nxt       = '0;
          remaining_nxt = remaining - 16'd1;
          position_nxt  = dir ? (position + 16'sd1) : (position - 16'sd1);
          if (abort || abort_pend) begin
            state_nxt  = S_DONE;
            status_nxt = ST_ABORTED;
          end else begin
            state_nxt = S_LOW;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      S_LOW: begin
        if (abort) begin
          state_nxt  = S_DONE;
          status_nxt = ST_ABORTED;
        end else if (cnt == HP_LAST) begin
          if (remaining == 16'd0) begin
            state_nxt  = S_DONE;
            status_nxt = ST_COMPLETE;
          end else begin
            want_high = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Every entry into HIGH is gated by the soft limit in the travel direction.
    if (want_high) begin
      cnt_nxt  = '0;
      at_limit = (dir_nxt && (position_nxt == POS_MAX)) ||
                 (!dir_nxt && (position_nxt == POS_MIN));
      if (at_limit) begin
        state_nxt  = S_DONE;
        status_nxt = ST_LIMIT;
      end else begin
        state_nxt = S_HIGH;
      end
    end
  end

  // State and datapath registers; reset discards any move in flight.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      remaining  <= '0;
      position   <= '0;
      dir        <= 1'b0;
      status     <= ST_COMPLETE;
      abort_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      remaining  <= remaining_nxt;
      position   <= position_nxt;
      dir        <= dir_nxt;
      status     <= status_nxt;
      abort_pend <= abort_pend_nxt;
    end
  end

endmodule
